nibble_serial_adder16: RTL and testbench
========================================

Name: nibble_serial_adder16

Overview:
- Multi-cycle 16-bit adder for the Computer16 datapath, built around one 4-bit adder slice.
- Latches two 16-bit operands, then adds one nibble per cycle, least significant nibble first, over 4 cycles.
- Carries the ripple carry between nibbles in a register.
- Presents sum, carry-out and signed overflow with a start/done handshake.
- Sits directly downstream of the 4-bit adder slice, consuming its sum/carry each cycle; trades latency for area versus four chained slices.

Parameters:
- NIBBLES, 4, number of 4-bit slices processed (operand width = 4*NIBBLES; only 4 is required to be supported and verified).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; accepted only while busy=0 and done=0
- a  input  16  operand A, sampled on the accepting edge
- b  input  16  operand B, sampled on the accepting edge
- cin  input  1  carry into nibble 0, sampled on the accepting edge
- busy  output  1  high while nibbles are being processed
- done  output  1  one-cycle pulse; sum/cout/ovf valid from this cycle on
- sum  output  16  result
- cout  output  1  carry out of bit 15
- ovf  output  1  signed overflow (carry into bit 15 XOR carry out of bit 15)

Behaviour:
- Reset: one clock; reset is synchronous and active-low, sampled on the rising edge of clk. When rst_n=0, the state goes to IDLE and busy, done, sum, cout, ovf and the nibble counter all clear to 0.
- Reset mid-operation: abandons the operation with no done pulse. Operand registers may hold stale values but must not be observable.
- State machine, three states:
  - IDLE: busy=0, done=0. If start=1, latch a, b and cin into opA, opB and the carry register, clear cnt to 0, and go to RUN.
  - RUN: busy=1. Each cycle, the 4-bit slice computes {c, s} = opA[cnt] + opB[cnt] + carry. s is written to sum[4*cnt+3:4*cnt] and c to the carry register. When cnt=3, go to DONE; otherwise cnt increments. cnt is 2 bits and never wraps inside RUN.
  - DONE: busy=0, done=1 for exactly one cycle. cout is the final carry. ovf = a[15]^b[15]^sum[15]^cout (latched operand bits). Always returns to IDLE next cycle.
- Latency: start sampled at edge N gives busy=1 for cycles N+1..N+4 and done=1 in cycle N+5.
- sum: nibbles update progressively during RUN. Only values held in DONE and afterwards are guaranteed. sum, cout and ovf hold their values until the next accepted start.
- start while busy=1 or in DONE: ignored, not queued.
- start held continuously: a new operation is accepted in every IDLE cycle, giving back-to-back ops with one idle cycle between done and the next busy.
- Operand inputs: changes after the accepting edge have no effect.
- Arithmetic: unsigned modulo 2^16 plus cout. No saturation.

Optional Feature:
- Macro SUB_EN.
- Defined: adds input port sub (1 bit), sampled with the operands. With sub=1, opB latches ~b and the carry register latches 1 (cin ignored), so the result is a-b. cout=1 means no borrow. ovf keeps the same formula applied to the inverted operand.
- Undefined: the sub port does not exist and the block only adds.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 with start=0 -> busy=0, done=0, sum=0000, cout=0, ovf=0 on every cycle.
- Basic add: a=1234, b=4321, cin=0, start for 1 cycle -> done in the 5th cycle after the accepting edge, sum=5555, cout=0, ovf=0.
- Full carry ripple: a=FFFF, b=0000, cin=1 -> sum=0000, cout=1, ovf=0. The carry register is 1 after every nibble.
- Signed overflow: a=7FFF, b=0001, cin=0 -> sum=8000, cout=0, ovf=1. Then a=8000, b=8000 -> sum=0000, cout=1, ovf=1.
- Ignored start and mid-op reset: start asserted again 2 cycles after acceptance -> no extra done and no result change. A separate run with rst_n=0 in the 3rd RUN cycle -> outputs 0, no done pulse, IDLE next cycle.
- SUB_EN build: a=0005, b=0007, sub=1 -> sum=FFFE, cout=0, ovf=0. a=8000, b=0001, sub=1 -> sum=7FFF, cout=1, ovf=1.

Source files
------------

// File: rtl/nibble_serial_adder16.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder16
//
// Multi-cycle adder for the Computer16 datapath. A single 4-bit adder slice is
// reused over NIBBLES cycles, least significant nibble first. The ripple carry
// between nibbles is kept in a register. This gives more latency than a chain
// of slices, but only one slice is built.
//
// Optional feature (macro SUB_EN):
//   When SUB_EN is defined, the block gains a 'sub' input. With sub=1 it
//   latches ~b and forces the carry-in to 1, so the result is a-b. In that case
//   cout=1 means no borrow occurred.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   start  in   request; accepted only in IDLE (busy=0, done=0)
//   a, b   in   operands, sampled on the accepting edge
//   cin    in   carry into nibble 0, sampled on the accepting edge
//   sub    in   (SUB_EN only) subtract select, sampled with the operands
//   busy   out  high while nibbles are being processed
//   done   out  one-cycle pulse; sum/cout/ovf valid from this cycle on
//   sum    out  result
//   cout   out  carry out of the top bit
//   ovf    out  signed overflow (carry into MSB xor carry out of MSB)
//
// Timing: start sampled at edge N gives busy=1 in cycles N+1..N+4 and
// done=1 in cycle N+5. The result holds until the next accepted start.
// -----------------------------------------------------------------------------
module nibble_serial_adder16 #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
`ifdef SUB_EN
    input  logic                   sub,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The shared 4-bit slice. It returns {carry_out, sum_nibble}.
    function automatic logic [4:0] add_nibble(input logic [3:0] x,
                                              input logic [3:0] y,
                                              input logic       ci);
        return {1'b0, x} + {1'b0, y} + {4'b0000, ci};
    endfunction

    // Signed overflow, computed from the sign bits of the operands and the result.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic s_msb,
                                        input logic c_out);
        return a_msb ^ b_msb ^ s_msb ^ c_out;
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic            accept_s;
    logic            last_s;
    logic            busy_nxt_s;
    logic            done_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [CW+1:0]   base_s;
    logic [W-1:0]    opa_r;
    logic [W-1:0]    opb_r;
    logic            carry_r;
    logic [W-1:0]    opb_in_s;
    logic            cin_in_s;
    logic [4:0]      slice_s;
    logic            busy_r;
    logic            done_r;
    logic [W-1:0]    sum_r;
    logic            cout_r;
    logic            ovf_r;

    assign base_s  = {cnt_r, 2'b00};
    assign last_s  = (cnt_r == LAST_CNT);
    assign slice_s = add_nibble(opa_r[base_s +: 4], opb_r[base_s +: 4], carry_r);

    // Select the operand B and carry-in values that are latched on acceptance
    // (they are inverted/forced when subtracting).
    always_comb begin
        opb_in_s = b;
        cin_in_s = cin;
`ifdef SUB_EN
        if (sub) begin
            opb_in_s = ~b;
            cin_in_s = 1'b1;
        end else begin
            opb_in_s = b;
            cin_in_s = cin;
        end
`endif
    end

    // Next-state logic and next values of the registered handshake outputs.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
        busy_nxt_s = (state_nxt_s == ST_RUN);
        done_nxt_s = (state_nxt_s == ST_DONE);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: latch operands, process one nibble per RUN cycle, and capture the result flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            cnt_r   <= '0;
            opa_r   <= '0;
            opb_r   <= '0;
            carry_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            if (accept_s) begin
                opa_r   <= a;
                opb_r   <= opb_in_s;
                carry_r <= cin_in_s;
                cnt_r   <= '0;
            end else if (state_r == ST_RUN) begin
                sum_r[base_s +: 4] <= slice_s[3:0];
                carry_r            <= slice_s[4];
                if (last_s) begin
                    // The top nibble is processed here, so the final flags are known.
                    cout_r <= slice_s[4];
                    ovf_r  <= signed_ovf(opa_r[W-1], opb_r[W-1], slice_s[3], slice_s[4]);
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_nibble_serial_adder16.sv
module tb_nibble_serial_adder16;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
`ifdef SUB_EN
    logic        sub;
`endif
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int   tests;
    int   fails;
    exp_t sb_q[$];

    nibble_serial_adder16 #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Run one operation. If inj is nonzero, start is pulsed again at that RUN cycle.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                         input logic ts, input exp_t e, input int inj, input string nm);
        int   cyc;
        logic busy_ok;
        exp_t got;
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
`ifdef SUB_EN
        sub = ts;
`endif
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
`ifdef SUB_EN
        sub = 1'($urandom);
`endif
        cyc = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == inj) begin
                start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (!done && !busy) busy_ok = 1'b0;
        end while (!done && cyc < 20);
        check({nm, " latency"}, 32'(cyc), 32'd5);
        check({nm, " busy in run"}, 32'(busy_ok), 32'd1);
        check({nm, " busy in done"}, 32'(busy), 32'd0);
        if (sb_q.size() > 0) begin
            got = sb_q.pop_front();
            check({nm, " sum"}, 32'(sum), 32'(got.sum));
            check({nm, " cout"}, 32'(cout), 32'(got.cout));
            check({nm, " ovf"}, 32'(ovf), 32'(got.ovf));
        end else begin
            check({nm, " scoreboard empty"}, 32'd0, 32'd1);
        end
        @(negedge clk);
        check({nm, " done pulse width"}, 32'(done), 32'd0);
        check({nm, " sum held"}, 32'(sum), 32'(e.sum));
    endtask

    initial begin
        vec_t vecs[8];
        int   dones;
        int   first_k;
        int   second_k;
        exp_t got;

        tests = 0; fails = 0;
        rst_n = 1'b0; start = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0;
`ifdef SUB_EN
        sub = 1'b0;
`endif
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1};

        // Reset for two cycles, then stay idle.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle busy", 32'(busy), 32'd0);
            check("idle done", 32'(done), 32'd0);
            check("idle sum", 32'(sum), 32'd0);
            check("idle cout_ovf", 32'({cout, ovf}), 32'd0);
        end

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                  '{vecs[i].sum, vecs[i].cout, vecs[i].ovf}, 0, $sformatf("vec%0d", i));
        end

        // A second start during RUN must be ignored: there is no extra done pulse.
        do_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, '{16'h1010, 1'b0, 1'b0}, 2, "ignored start");
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("ignored start extra done", 32'(dones), 32'd0);
        check("ignored start result", 32'(sum), 32'h1010);

        // Holding start gives back-to-back operations with dones six cycles apart.
        @(negedge clk);
        a = 16'h0102; b = 16'h0304; cin = 1'b1; start = 1'b1;
        sb_q.push_back('{16'h0407, 1'b0, 1'b0});
        sb_q.push_back('{16'h0407, 1'b0, 1'b0});
        dones = 0; first_k = 0; second_k = 0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == 7) start = 1'b0;
            if (done) begin
                dones++;
                if (dones == 1) first_k = k; else second_k = k;
                if (sb_q.size() > 0) begin
                    got = sb_q.pop_front();
                    check("b2b sum", 32'(sum), 32'(got.sum));
                    check("b2b cout_ovf", 32'({cout, ovf}), 32'({got.cout, got.ovf}));
                end else begin
                    check("b2b scoreboard empty", 32'd0, 32'd1);
                end
            end
        end
        check("b2b done count", 32'(dones), 32'd2);
        check("b2b first done", 32'(first_k), 32'd5);
        check("b2b second done", 32'(second_k), 32'd11);
        sb_q.delete();

        // Reset in the third RUN cycle abandons the operation.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst sum", 32'(sum), 32'd0);
        check("midrst cout_ovf", 32'({cout, ovf}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("midrst no activity", 32'(dones), 32'd0);
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b0}, 0, "after reset");

`ifdef SUB_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0}, 0, "sub 5-7");
        do_op(16'h8000, 16'h0001, 1'b1, 1'b1, '{16'h7FFF, 1'b1, 1'b1}, 0, "sub 8000-1");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
